// File: rtl/lap_recorder.sv
// Lap/split capture between the stopwatch counter and the display driver: ring buffer of laps,
// timed display freeze after a lap, and lap recall. Define LAP_OVERWRITE_EN to let laps overwrite the oldest entry when full.
module lap_recorder #(
    parameter int DEPTH   = 8,
    parameter int HOLD_MS = 2000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_1ms,
    input  logic                       running,
    input  logic                       lap_edge,
    input  logic                       recall_edge,
    input  logic                       clear_edge,
    input  logic [6:0]                 live_cs,
    input  logic [5:0]                 live_sec,
    input  logic [5:0]                 live_min,
    output logic [6:0]                 disp_cs,
    output logic [5:0]                 disp_sec,
    output logic [5:0]                 disp_min,
    output logic [1:0]                 mode,
    output logic [$clog2(DEPTH):0]     lap_count,
    output logic [$clog2(DEPTH)-1:0]   lap_index,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(HOLD_MS + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_MS - 1);

    typedef enum logic [1:0] {
        LIVE   = 2'b00,
        HOLD   = 2'b01,
        RECALL = 2'b10
    } state_t;

    state_t        state;
    logic [18:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] old_ptr;
    logic [TW-1:0] hold_timer;
    logic [18:0]   live_word;
    logic          is_full;
    logic          lap_acc;
    logic          overwrite;
    logic [PW-1:0] next_old;
    logic [CW-1:0] next_count;
    logic          last_idx;

    assign live_word = {live_min, live_sec, live_cs};
    assign mode      = state;

    always_comb begin
        is_full = (lap_count == FULL_COUNT);
`ifdef LAP_OVERWRITE_EN
        lap_acc   = lap_edge && running && !clear_edge;
        overwrite = lap_acc && is_full;
`else
        lap_acc   = lap_edge && running && !is_full && !clear_edge;
        overwrite = 1'b0;
`endif
        next_old   = overwrite ? old_ptr + PW'(1) : old_ptr;
        next_count = overwrite ? lap_count : lap_count + CW'(1);
        last_idx   = ((CW'(lap_index) + CW'(1)) == lap_count);
    end

    // A lap written this cycle may land on the slot being displayed; forward it.
    function automatic logic [18:0] entry_at(input logic [PW-1:0] addr);
        if (lap_acc && addr == wr_ptr) return live_word;
        return mem[addr];
    endfunction

    always_ff @(posedge clk) begin
        if (lap_acc) mem[wr_ptr] <= live_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                         <= LIVE;
            wr_ptr                        <= '0;
            old_ptr                       <= '0;
            hold_timer                    <= '0;
            lap_count                     <= '0;
            lap_index                     <= '0;
            full                          <= 1'b0;
            {disp_min, disp_sec, disp_cs} <= '0;
        end else if (clear_edge) begin
            state                         <= LIVE;
            wr_ptr                        <= '0;
            old_ptr                       <= '0;
            hold_timer                    <= '0;
            lap_count                     <= '0;
            lap_index                     <= '0;
            full                          <= 1'b0;
            {disp_min, disp_sec, disp_cs} <= live_word;
        end else begin
            if (lap_acc) begin
                wr_ptr    <= wr_ptr + PW'(1);
                old_ptr   <= next_old;
                lap_count <= next_count;
                full      <= (next_count == FULL_COUNT);
            end
            case (state)
                LIVE: begin
                    if (lap_acc) begin
                        state                         <= HOLD;
                        hold_timer                    <= '0;
                        {disp_min, disp_sec, disp_cs} <= live_word;
                    end else if (recall_edge && lap_count != '0) begin
                        state                         <= RECALL;
                        lap_index                     <= '0;
                        {disp_min, disp_sec, disp_cs} <= entry_at(old_ptr);
                    end else begin
                        {disp_min, disp_sec, disp_cs} <= live_word;
                    end
                end
                HOLD: begin
                    if (lap_acc) begin
                        hold_timer                    <= '0;
                        {disp_min, disp_sec, disp_cs} <= live_word;
                    end else if (recall_edge) begin
                        state                         <= RECALL;
                        hold_timer                    <= '0;
                        lap_index                     <= '0;
                        {disp_min, disp_sec, disp_cs} <= entry_at(old_ptr);
                    end else if (clk_1ms) begin
                        if (hold_timer == HOLD_LAST) begin
                            state                         <= LIVE;
                            hold_timer                    <= '0;
                            {disp_min, disp_sec, disp_cs} <= live_word;
                        end else begin
                            hold_timer <= hold_timer + TW'(1);
                        end
                    end
                end
                RECALL: begin
                    if (lap_acc) begin
                        {disp_min, disp_sec, disp_cs} <= entry_at(next_old + lap_index);
                    end else if (recall_edge) begin
                        if (last_idx) begin
                            state                         <= LIVE;
                            lap_index                     <= '0;
                            {disp_min, disp_sec, disp_cs} <= live_word;
                        end else begin
                            lap_index                     <= lap_index + PW'(1);
                            {disp_min, disp_sec, disp_cs} <= entry_at(old_ptr + lap_index + PW'(1));
                        end
                    end else begin
                        {disp_min, disp_sec, disp_cs} <= entry_at(old_ptr + lap_index);
                    end
                end
                default: begin
                    state     <= LIVE;
                    lap_index <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder: expected {mode, count, index, full, display} words are
// queued as stimulus is driven and popped when the registered outputs are sampled.
module tb_lap_recorder;
    localparam int DEPTH   = 8;
    localparam int HOLD_MS = 2000;
`ifdef LAP_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_1ms = 1'b0;
    logic        running = 1'b0;
    logic        lap_edge = 1'b0;
    logic        recall_edge = 1'b0;
    logic        clear_edge = 1'b0;
    logic [6:0]  live_cs = '0;
    logic [5:0]  live_sec = '0;
    logic [5:0]  live_min = '0;
    logic [6:0]  disp_cs;
    logic [5:0]  disp_sec;
    logic [5:0]  disp_min;
    logic [1:0]  mode;
    logic [3:0]  lap_count;
    logic [2:0]  lap_index;
    logic        full;

    lap_recorder #(.DEPTH(DEPTH), .HOLD_MS(HOLD_MS)) dut (
        .clk(clk), .rst_n(rst_n), .clk_1ms(clk_1ms), .running(running),
        .lap_edge(lap_edge), .recall_edge(recall_edge), .clear_edge(clear_edge),
        .live_cs(live_cs), .live_sec(live_sec), .live_min(live_min),
        .disp_cs(disp_cs), .disp_sec(disp_sec), .disp_min(disp_min),
        .mode(mode), .lap_count(lap_count), .lap_index(lap_index), .full(full)
    );

    // clock / reset
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [28:0] exp_q[$];
    logic [28:0] exp_v;
    logic [28:0] obs;
    logic [18:0] model_q[$];

    assign obs = {mode, lap_count, lap_index, full, disp_min, disp_sec, disp_cs};

    function automatic logic [18:0] t(input int m, input int s, input int c);
        return {m[5:0], s[5:0], c[6:0]};
    endfunction

    function automatic logic [28:0] pack(input logic [1:0] m, input int cnt, input int idx, input logic [18:0] d);
        return {m, 4'(cnt), 3'(idx), (cnt == DEPTH), d};
    endfunction

    function automatic logic [18:0] live_now();
        return {live_min, live_sec, live_cs};
    endfunction

    // driver: inputs change on the falling edge, outputs are sampled on the next falling edge
    task automatic cycle(input logic lap, input logic rec, input logic clr, input logic tick);
        lap_edge = lap; recall_edge = rec; clear_edge = clr; clk_1ms = tick;
        @(negedge clk);
        lap_edge = 1'b0; recall_edge = 1'b0; clear_edge = 1'b0; clk_1ms = 1'b0;
    endtask

    task automatic set_live(input logic [18:0] v);
        {live_min, live_sec, live_cs} = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; running = 1'b1; set_live(t(1, 23, 45));
        repeat (2) @(negedge clk);
        exp_q.push_back(pack(2'b00, 0, 0, 19'd0));
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
        rst_n = 1'b1;
        exp_q.push_back(pack(2'b00, 0, 0, t(1, 23, 45)));
        cycle(0, 0, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL live_follow: got %h want %h", obs, exp_v); end
        set_live(t(2, 0, 7));
        exp_q.push_back(pack(2'b00, 0, 0, t(2, 0, 7)));
        cycle(0, 0, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL live_latency: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_lap_hold();
        set_live(t(1, 23, 45));
        exp_q.push_back(pack(2'b01, 1, 0, t(1, 23, 45)));
        cycle(1, 0, 0, 1);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lap_entry: got %h want %h", obs, exp_v); end
        set_live(t(5, 5, 5));
        repeat (HOLD_MS - 1) begin
            cycle(0, 0, 0, 1);
            cycle(0, 0, 0, 0);
        end
        exp_q.push_back(pack(2'b01, 1, 0, t(1, 23, 45)));
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hold_before_last_tick: got %h want %h", obs, exp_v); end
        exp_q.push_back(pack(2'b00, 1, 0, t(5, 5, 5)));
        cycle(0, 0, 0, 1);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hold_expire: got %h want %h", obs, exp_v); end
        set_live(t(6, 7, 8));
        exp_q.push_back(pack(2'b00, 1, 0, t(6, 7, 8)));
        cycle(0, 0, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL live_after_hold: got %h want %h", obs, exp_v); end
        exp_q.push_back(pack(2'b00, 0, 0, t(6, 7, 8)));
        cycle(0, 0, 1, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clear_live: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_recall();
        for (int k = 1; k <= 3; k++) begin
            set_live(t(0, k, 0));
            exp_q.push_back(pack(2'b01, k, 0, t(0, k, 0)));
            cycle(1, 0, 0, 0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL recall_setup_lap%0d: got %h want %h", k, obs, exp_v); end
        end
        set_live(t(9, 9, 9));
        for (int i = 0; i < 3; i++) exp_q.push_back(pack(2'b10, 3, i, t(0, i + 1, 0)));
        exp_q.push_back(pack(2'b00, 3, 0, t(9, 9, 9)));
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL recall_step%0d: got %h want %h", i, obs, exp_v); end
        end
        exp_q.push_back(pack(2'b10, 3, 0, t(0, 1, 0)));
        cycle(0, 1, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL recall_reenter: got %h want %h", obs, exp_v); end
        set_live(t(0, 4, 0));
        exp_q.push_back(pack(2'b10, 4, 0, t(0, 1, 0)));
        cycle(1, 0, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lap_in_recall: got %h want %h", obs, exp_v); end
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_ignored();
        running = 1'b0; set_live(t(3, 3, 3));
        exp_q.push_back(pack(2'b00, 0, 0, t(3, 3, 3)));
        cycle(1, 0, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lap_not_running: got %h want %h", obs, exp_v); end
        exp_q.push_back(pack(2'b00, 0, 0, t(3, 3, 3)));
        cycle(0, 1, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL recall_empty: got %h want %h", obs, exp_v); end
        running = 1'b1;
        exp_q.push_back(pack(2'b01, 1, 0, t(3, 3, 3)));
        cycle(1, 1, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lap_beats_recall: got %h want %h", obs, exp_v); end
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_full();
        logic [18:0] shown;
        model_q.delete();
        shown = '0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            set_live(t(0, k, k));
            if (model_q.size() < DEPTH || OVW) begin
                if (model_q.size() == DEPTH) void'(model_q.pop_front());
                model_q.push_back(t(0, k, k));
                shown = t(0, k, k);
            end
            exp_q.push_back(pack(2'b01, model_q.size(), 0, shown));
            cycle(1, 0, 0, 0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL fill_lap%0d: got %h want %h", k, obs, exp_v); end
        end
        set_live(t(7, 7, 7));
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(pack(2'b10, DEPTH, i, model_q[i]));
        exp_q.push_back(pack(2'b00, DEPTH, 0, t(7, 7, 7)));
        for (int i = 0; i <= DEPTH; i++) begin
            cycle(0, 1, 0, 0);
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL full_walk%0d: got %h want %h", i, obs, exp_v); end
        end
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_clear_in_hold();
        set_live(t(0, 9, 9));
        exp_q.push_back(pack(2'b01, 1, 0, t(0, 9, 9)));
        cycle(1, 0, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hold_before_clear: got %h want %h", obs, exp_v); end
        set_live(t(0, 10, 1));
        exp_q.push_back(pack(2'b00, 0, 0, t(0, 10, 1)));
        cycle(1, 0, 1, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clear_beats_lap: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 5; k++) begin
            set_live(t(2, k, 10 + k));
            cycle(1, 0, 0, 0);
        end
        exp_q.push_back(pack(2'b01, 5, 0, t(2, 5, 15)));
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL five_laps: got %h want %h", obs, exp_v); end
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(pack(2'b00, 0, 0, 19'd0));
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset: got %h want %h", obs, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(pack(2'b00, 0, 0, t(2, 5, 15)));
        cycle(0, 0, 0, 0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL post_reset: got %h want %h", obs, exp_v); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lap_hold();
        test_recall();
        test_ignored();
        test_full();
        test_clear_in_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
